fifo_stream_ctrl: RTL and testbench
===================================

# fifo_stream_ctrl

Controller that sequences the synchronous FIFO in the CSR+FIFO subsystem. It round-robin arbitrates two upstream sample sources (e.g. two ECG channels) onto the FIFO write port. On the read side, it drains the FIFO in bursts onto a valid/ready output stream whenever the FIFO level reaches a CSR-programmed threshold, or on flush. It sits between the sources, the FIFO, and the consumer, gated by CONTROL[0].

## Interface
Parameters:
- DATA_WIDTH, 32, sample/FIFO word width; also the FIFO level width
- BURST_LEN, 8, maximum words per drain burst (≥1)

Ports:
- ACLK  in  1  single clock
- ARESETn  in  1  asynchronous active-low reset
- enable_i  in  1  CONTROL[0]; 0 blocks all new writes and new bursts
- flush_i  in  1  level-sensitive; when high, a burst starts on any non-empty FIFO
- thresh_i  in  DATA_WIDTH  drain threshold, unsigned; 0 is treated as 1
- s0_valid_i / s1_valid_i  in  1  source request
- s0_data_i / s1_data_i  in  DATA_WIDTH  source data
- s0_ready_o / s1_ready_o  out  1  source accepted this cycle
- fifo_wr_en_o  out  1  FIFO write enable
- fifo_data_in_o  out  DATA_WIDTH  FIFO write data (mux of granted source)
- fifo_rd_en_o  out  1  FIFO read enable
- fifo_data_out_i  in  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_en_o
- fifo_empty_i, fifo_full_i  in  1  FIFO flags
- fifo_level_i  in  DATA_WIDTH  FIFO occupancy
- m_valid_o  out  1  output word valid
- m_data_o  out  DATA_WIDTH  output word
- m_last_o  out  1  final word of the burst
- m_ready_i  in  1  consumer ready
- busy_o  out  1  drain FSM not in IDLE
- burst_cnt_o  out  16  completed bursts (present only with FIFO_CTRL_BURST_CNT_EN)

## Operation
- Write arbiter (combinational grant, registered pointer):
  - pointer rr_q selects the preferred source; if only one source is valid, that source wins.
  - write enable: fifo_wr_en_o = enable_i & ~fifo_full_i & (s0_valid_i | s1_valid_i).
  - ready: the granted source's ready equals fifo_wr_en_o; the other source's ready is 0.
  - pointer update: after an accepted write, rr_q moves to the non-granted source.
  - FIFO full blocks writes even if a read occurs in the same cycle.
- Drain FSM states: IDLE, RD, LOAD, OUT.
  - IDLE→RD: when enable_i & ~fifo_empty_i & (fifo_level_i ≥ max(thresh_i,1) | flush_i). Clears beat count cnt_q.
  - RD: fifo_rd_en_o=1 for exactly one cycle, then LOAD.
  - LOAD: registers fifo_data_out_i into m_data_o. Sets m_last_o = (cnt_q==BURST_LEN-1) | fifo_empty_i. Goes to OUT.
  - OUT: m_valid_o=1 until m_ready_i. On handshake:
    - if m_last_o or ~enable_i → IDLE (a burst counts as completed only with m_last_o);
    - else cnt_q+1 and RD.
- Boundary conditions:
  - Enable dropped mid-burst: the word already in RD/LOAD/OUT completes, with no new reads; m_last_o is not forced.
  - cnt_q width is clog2(BURST_LEN); it never wraps inside a burst.
  - Simultaneous write and drain are independent; the FIFO handles concurrent rd/wr.
- Reset (async): every output is 0, FSM in IDLE, rr_q = source 0, cnt_q = 0, burst_cnt_o = 0.

## Timing
- Write path is zero latency: fifo_wr_en_o is combinational from valid/full/enable.
- Drain: first m_valid_o rises 2 cycles after RD entry (RD→LOAD→OUT). Each further word costs at least 3 cycles.
- Stream rules: m_data_o and m_last_o are stable while m_valid_o=1 and m_ready_i=0. m_valid_o never drops without a handshake, except on reset.

## Configuration
- FIFO_CTRL_BURST_CNT_EN defined: burst_cnt_o is a 16-bit register that increments on each OUT handshake with m_last_o=1 and wraps 0xFFFF→0.
- Not defined: the port and its register are absent; behaviour is otherwise identical.

## Test plan
- Reset with both sources valid and the FIFO non-empty → all outputs 0, no rd/wr until ARESETn=1. Reset asserted in OUT → m_valid_o drops immediately.
- Both sources valid continuously, enable=1, FIFO not full → writes alternate s0,s1,s0,… (data 0xA0.. / 0xB0..), one per cycle, and each ready pulses only on its grant.
- thresh=4, feed 4 words 1..4, BURST_LEN=8, m_ready=1 → burst outputs 1,2,3,4 in order; m_last on 4; busy returns low.
- thresh=2, level=10, BURST_LEN=8, m_ready toggling → exactly 8 words with m_last on the 8th; a second burst then starts for the remaining 2 words, and m_last is set on the 2nd via empty.
- fifo_full=1 with s0 valid → s0_ready_o=0, no write. Enable=0 mid-OUT → current word completes, FSM goes to IDLE, no further rd_en.
- With FIFO_CTRL_BURST_CNT_EN, run 3 bursts → burst_cnt_o=3. Preload 0xFFFF via 65535 bursts (or a forced value) → the next burst wraps it to 0.

Source files
------------

// File: rtl/fifo_stream_ctrl.sv
// fifo_stream_ctrl: round-robin two sample sources into a FIFO; drain the FIFO in bursts onto a valid/ready stream.
// Latency: write path is combinational (0 cycles); first drained word is valid 2 cycles after RD, >=3 cycles per word.
// Backpressure: FIFO full deasserts both source readies; m_ready_i low holds the current output word until accepted.
// Option: define FIFO_CTRL_BURST_CNT_EN to add the 16-bit completed-burst counter on burst_cnt_o.
module fifo_stream_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  enable_i,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] thresh_i,
  input  logic                  s0_valid_i,
  input  logic [DATA_WIDTH-1:0] s0_data_i,
  output logic                  s0_ready_o,
  input  logic                  s1_valid_i,
  input  logic [DATA_WIDTH-1:0] s1_data_i,
  output logic                  s1_ready_o,
  output logic                  fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0] fifo_data_in_o,
  output logic                  fifo_rd_en_o,
  input  logic [DATA_WIDTH-1:0] fifo_data_out_i,
  input  logic                  fifo_empty_i,
  input  logic                  fifo_full_i,
  input  logic [DATA_WIDTH-1:0] fifo_level_i,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  input  logic                  m_ready_i,
  output logic                  busy_o
`ifdef FIFO_CTRL_BURST_CNT_EN
  ,
  output logic [15:0]           burst_cnt_o
`endif
);

  // A single-word burst still needs a 1-bit counter so the compare below is well formed.
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [DATA_WIDTH-1:0] THR_ONE = DATA_WIDTH'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_LOAD = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  rr_q, rr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_last_q, m_last_d;

  logic                  any_vld;
  logic                  gnt1;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] thr_eff;
  logic                  start;
  logic                  handshake;

  // Write arbiter: rr_q names the preferred source (1 = s1); a lone requester always wins.
  // Reset also gates the enable so no write can leak out while ARESETn is low.
  always_comb begin
    any_vld = s0_valid_i | s1_valid_i;
    gnt1    = s1_valid_i & (~s0_valid_i | rr_q);
    wr_en   = ARESETn & enable_i & ~fifo_full_i & any_vld;
    rr_d    = rr_q;
    if (wr_en) begin
      rr_d = ~gnt1;
    end
  end

  assign fifo_wr_en_o   = wr_en;
  assign s0_ready_o     = wr_en & ~gnt1;
  assign s1_ready_o     = wr_en & gnt1;
  assign fifo_data_in_o = wr_en ? (gnt1 ? s1_data_i : s0_data_i) : '0;

  // Drain FSM: one FIFO read per word, data captured the cycle after rd_en, then held until accepted.
  always_comb begin
    thr_eff   = (thresh_i == '0) ? THR_ONE : thresh_i;
    start     = enable_i & ~fifo_empty_i & ((fifo_level_i >= thr_eff) | flush_i);
    handshake = (state_q == S_OUT) & m_ready_i;
    state_d   = state_q;
    cnt_d     = cnt_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RD;
          cnt_d   = '0;
        end
      end
      S_RD: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        // fifo_empty_i already reflects the read issued in RD, so empty here means this was the last word.
        m_data_d = fifo_data_out_i;
        m_last_d = (cnt_q == CNT_LAST) | fifo_empty_i;
        state_d  = S_OUT;
      end
      S_OUT: begin
        if (m_ready_i) begin
          if (m_last_q | ~enable_i) begin
            state_d = S_IDLE;
          end else begin
            // m_last_q is forced at CNT_LAST, so this increment cannot wrap.
            cnt_d   = cnt_q + 1'b1;
            state_d = S_RD;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Controller state registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q  <= S_IDLE;
      rr_q     <= 1'b0;
      cnt_q    <= '0;
      m_data_q <= '0;
      m_last_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      m_data_q <= m_data_d;
      m_last_q <= m_last_d;
    end
  end

  assign fifo_rd_en_o = (state_q == S_RD);
  assign m_valid_o    = (state_q == S_OUT);
  assign m_data_o     = m_data_q;
  assign m_last_o     = m_last_q;
  assign busy_o       = (state_q != S_IDLE);

`ifdef FIFO_CTRL_BURST_CNT_EN
  logic [15:0] burst_cnt_q, burst_cnt_d;

  // Completed-burst counter: only a handshake on the last word counts; wraps naturally at 16 bits.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (handshake & m_last_q) begin
      burst_cnt_d = burst_cnt_q + 16'd1;
    end
  end

  // Burst counter register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      burst_cnt_q <= 16'd0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign burst_cnt_o = burst_cnt_q;
`else
  logic unused_handshake;
  assign unused_handshake = handshake;
`endif

endmodule

// File: tb/tb_fifo_stream_ctrl.sv
// tb_fifo_stream_ctrl: directed stimulus with write and output scoreboards around fifo_stream_ctrl.
// Latency: bench FIFO model returns read data one cycle after fifo_rd_en_o.
// Backpressure: m_ready_i driven per test (held low, high or toggling); FIFO full can be forced.
module tb_fifo_stream_ctrl;
  localparam int DW = 32;

  logic          ACLK = 1'b0;
  logic          ARESETn;
  logic          enable_i, flush_i;
  logic [DW-1:0] thresh_i;
  logic          s0_valid_i, s1_valid_i;
  logic [DW-1:0] s0_data_i, s1_data_i;
  logic          s0_ready_o, s1_ready_o;
  logic          fifo_wr_en_o, fifo_rd_en_o;
  logic [DW-1:0] fifo_data_in_o, fifo_data_out_i, fifo_level_i;
  logic          fifo_empty_i, fifo_full_i;
  logic          m_valid_o, m_last_o, m_ready_i, busy_o;
  logic [DW-1:0] m_data_o;
`ifdef FIFO_CTRL_BURST_CNT_EN
  logic [15:0]   burst_cnt_o;
`endif

  int total = 0;
  int bad   = 0;

  fifo_stream_ctrl #(.DATA_WIDTH(DW), .BURST_LEN(8)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .enable_i(enable_i), .flush_i(flush_i), .thresh_i(thresh_i),
    .s0_valid_i(s0_valid_i), .s0_data_i(s0_data_i), .s0_ready_o(s0_ready_o),
    .s1_valid_i(s1_valid_i), .s1_data_i(s1_data_i), .s1_ready_o(s1_ready_o),
    .fifo_wr_en_o(fifo_wr_en_o), .fifo_data_in_o(fifo_data_in_o), .fifo_rd_en_o(fifo_rd_en_o),
    .fifo_data_out_i(fifo_data_out_i), .fifo_empty_i(fifo_empty_i), .fifo_full_i(fifo_full_i),
    .fifo_level_i(fifo_level_i), .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_last_o(m_last_o),
    .m_ready_i(m_ready_i), .busy_o(busy_o)
`ifdef FIFO_CTRL_BURST_CNT_EN
    , .burst_cnt_o(burst_cnt_o)
`endif
  );

  always #5 ACLK = ~ACLK;

  // FIFO model (depth 16); flags update with NBAs so the DUT sees registered values.
  logic [DW-1:0] fq[$];
  logic [DW-1:0] pre_q[$];
  logic [DW-1:0] f_dout = '0;
  int            f_lvl  = 0;
  int            rd_cnt = 0;
  logic          full_force = 1'b0;

  always @(posedge ACLK) begin : fifo_model
    logic [DW-1:0] t;
    if (fifo_rd_en_o && fq.size() > 0) begin
      t = fq.pop_front();
      f_dout <= t;
    end
    if (fifo_rd_en_o) rd_cnt <= rd_cnt + 1;
    if (fifo_wr_en_o) fq.push_back(fifo_data_in_o);
    while (pre_q.size() > 0) fq.push_back(pre_q.pop_front());
    f_lvl <= fq.size();
  end

  assign fifo_data_out_i = f_dout;
  assign fifo_level_i    = DW'(f_lvl);
  assign fifo_empty_i    = (f_lvl == 0);
  assign fifo_full_i     = (f_lvl >= 16) | full_force;

  // Scoreboards: write queue holds {src, data}; output queue holds {last, data}.
  logic [DW:0] wq[$];
  logic [DW:0] oq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Write-side monitor.
  always @(negedge ACLK) begin : wr_mon
    logic [DW:0] e;
    if (fifo_wr_en_o) begin
      if (wq.size() == 0) begin
        total++; bad++;
        $display("FAIL wr_unexpected got=%0h want=none", fifo_data_in_o);
      end else begin
        e = wq.pop_front();
        chk("wr_data", 64'(fifo_data_in_o), 64'(e[DW-1:0]));
        chk("wr_s0_rdy", 64'(s0_ready_o), 64'(!e[DW]));
        chk("wr_s1_rdy", 64'(s1_ready_o), 64'(e[DW]));
      end
    end else if (s0_valid_i || s1_valid_i) begin
      chk("rdy_no_grant", 64'({s0_ready_o, s1_ready_o}), 64'd0);
    end
  end

  // Output-stream monitor.
  always @(negedge ACLK) begin : out_mon
    logic [DW:0] e;
    if (m_valid_o && m_ready_i) begin
      if (oq.size() == 0) begin
        total++; bad++;
        $display("FAIL out_unexpected got=%0h want=none", m_data_o);
      end else begin
        e = oq.pop_front();
        chk("out_data", 64'(m_data_o), 64'(e[DW-1:0]));
        chk("out_last", 64'(m_last_o), 64'(e[DW]));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int k = 0;
    while ((oq.size() != 0 || wq.size() != 0 || busy_o) && k < budget) begin
      cyc(1);
      k++;
    end
    if (k >= budget) begin
      total++; bad++;
      $display("FAIL %s_timeout got=%0d want=0 pending", nm, oq.size() + wq.size());
    end
  endtask

  task automatic wait_mvalid(input string nm, input int budget);
    int k = 0;
    while (!m_valid_o && k < budget) begin
      cyc(1);
      k++;
    end
    if (k >= budget) begin
      total++; bad++;
      $display("FAIL %s_timeout got=0 want=m_valid", nm);
    end
  endtask

  initial begin
    int rc;
    ARESETn = 1'b0; enable_i = 1'b1; flush_i = 1'b0; thresh_i = 32'd1;
    s0_valid_i = 1'b1; s1_valid_i = 1'b1; s0_data_i = 32'hA0; s1_data_i = 32'hB0;
    m_ready_i = 1'b1;
    pre_q.push_back(32'h55);

    // Reset with sources valid and FIFO non-empty: everything held at 0.
    cyc(3);
    #3;
    chk("rst_wr_en", 64'(fifo_wr_en_o), 64'd0);
    chk("rst_rd_en", 64'(fifo_rd_en_o), 64'd0);
    chk("rst_rdy", 64'({s0_ready_o, s1_ready_o}), 64'd0);
    chk("rst_din", 64'(fifo_data_in_o), 64'd0);
    chk("rst_mvalid", 64'(m_valid_o), 64'd0);
    chk("rst_mlast", 64'(m_last_o), 64'd0);
    chk("rst_mdata", 64'(m_data_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_level", 64'(fifo_level_i), 64'd1);
`ifdef FIFO_CTRL_BURST_CNT_EN
    chk("rst_bcnt", 64'(burst_cnt_o), 64'd0);
`endif
    s0_valid_i = 1'b0; s1_valid_i = 1'b0;
    oq.push_back({1'b1, 32'h55});
    cyc(1);
    ARESETn = 1'b1;
    wait_idle("t1", 40);

    // Alternating writes from both sources, then a flush drains all six.
    thresh_i = 32'd100;
    for (int k = 0; k < 6; k++) wq.push_back((k % 2 == 0) ? {1'b0, 32'hA0 + 32'(k / 2)} : {1'b1, 32'hB0 + 32'(k / 2)});
    for (int k = 0; k < 6; k++) begin
      s0_valid_i = 1'b1; s1_valid_i = 1'b1;
      s0_data_i = 32'hA0 + 32'(k / 2);
      s1_data_i = 32'hB0 + 32'(k / 2);
      cyc(1);
    end
    s0_valid_i = 1'b0; s1_valid_i = 1'b0;
    cyc(2);
    chk("t2_busy_no_thresh", 64'(busy_o), 64'd0);
    oq.push_back({1'b0, 32'hA0}); oq.push_back({1'b0, 32'hB0});
    oq.push_back({1'b0, 32'hA1}); oq.push_back({1'b0, 32'hB1});
    oq.push_back({1'b0, 32'hA2}); oq.push_back({1'b1, 32'hB2});
    flush_i = 1'b1;
    wait_idle("t2", 80);
    flush_i = 1'b0;

    // Threshold 4: four words 1..4 from s0 produce one burst ending on 4.
    thresh_i = 32'd4;
    for (int k = 1; k <= 4; k++) wq.push_back({1'b0, 32'(k)});
    for (int k = 1; k <= 4; k++) oq.push_back({(k == 4), 32'(k)});
    for (int k = 1; k <= 4; k++) begin
      s0_valid_i = 1'b1; s0_data_i = 32'(k);
      cyc(1);
    end
    s0_valid_i = 1'b0;
    wait_idle("t3", 60);
    chk("t3_busy_low", 64'(busy_o), 64'd0);

    // Threshold 2, ten words preloaded, toggling ready: burst of 8 then burst of 2.
    enable_i = 1'b0; thresh_i = 32'd2;
    for (int k = 0; k < 10; k++) pre_q.push_back(32'h100 + 32'(k));
    for (int k = 0; k < 10; k++) oq.push_back({(k == 7 || k == 9), 32'h100 + 32'(k)});
    cyc(2);
    chk("t4_level", 64'(fifo_level_i), 64'd10);
    enable_i = 1'b1;
    for (int k = 0; k < 200 && (oq.size() != 0 || busy_o); k++) begin
      m_ready_i = ~m_ready_i;
      cyc(1);
    end
    m_ready_i = 1'b1;
    wait_idle("t4", 20);
    chk("t4_empty", 64'(fifo_empty_i), 64'd1);

    // FIFO full blocks writes.
    full_force = 1'b1; s0_valid_i = 1'b1; s0_data_i = 32'h77;
    for (int k = 0; k < 3; k++) begin
      #3;
      chk("t5_s0_rdy", 64'(s0_ready_o), 64'd0);
      chk("t5_wr_en", 64'(fifo_wr_en_o), 64'd0);
      cyc(1);
    end
    s0_valid_i = 1'b0; full_force = 1'b0;
    cyc(1);

    // Enable dropped while a word waits in OUT: it completes, then no more reads.
    enable_i = 1'b0; thresh_i = 32'd1; m_ready_i = 1'b0;
    pre_q.push_back(32'h200); pre_q.push_back(32'h201); pre_q.push_back(32'h202);
    cyc(2);
    enable_i = 1'b1;
    wait_mvalid("t6", 20);
    enable_i = 1'b0;
    rc = rd_cnt;
    oq.push_back({1'b0, 32'h200});
    cyc(1);
    m_ready_i = 1'b1;
    cyc(5);
    chk("t6_busy", 64'(busy_o), 64'd0);
    chk("t6_mvalid", 64'(m_valid_o), 64'd0);
    chk("t6_no_rd", 64'(rd_cnt), 64'(rc));
    chk("t6_oq_drained", 64'(oq.size()), 64'd0);
    chk("t6_level", 64'(fifo_level_i), 64'd2);
    oq.push_back({1'b0, 32'h201}); oq.push_back({1'b1, 32'h202});
    enable_i = 1'b1;
    wait_idle("t6b", 40);

    // Reset asserted in OUT: m_valid_o drops at once.
    m_ready_i = 1'b0;
    pre_q.push_back(32'h300);
    wait_mvalid("t7", 20);
    #1;
    ARESETn = 1'b0;
    #1;
    chk("t7_mvalid", 64'(m_valid_o), 64'd0);
    chk("t7_busy", 64'(busy_o), 64'd0);
    chk("t7_mdata", 64'(m_data_o), 64'd0);
    cyc(1);
    ARESETn = 1'b1;
    m_ready_i = 1'b1;
    cyc(3);
    chk("t7_idle_after", 64'(busy_o), 64'd0);

`ifdef FIFO_CTRL_BURST_CNT_EN
    // Burst counter: three single-word bursts, then wrap from 0xFFFF.
    chk("t8_bcnt0", 64'(burst_cnt_o), 64'd0);
    for (int k = 0; k < 3; k++) begin
      pre_q.push_back(32'h400 + 32'(k));
      oq.push_back({1'b1, 32'h400 + 32'(k)});
      cyc(1);
      wait_idle("t8", 30);
    end
    chk("t8_bcnt3", 64'(burst_cnt_o), 64'd3);
    force dut.burst_cnt_q = 16'hFFFF;
    cyc(1);
    release dut.burst_cnt_q;
    chk("t8_bcnt_ffff", 64'(burst_cnt_o), 64'hFFFF);
    pre_q.push_back(32'h500);
    oq.push_back({1'b1, 32'h500});
    cyc(1);
    wait_idle("t8b", 30);
    chk("t8_bcnt_wrap", 64'(burst_cnt_o), 64'd0);
`endif

    cyc(2);
    chk("end_wq_empty", 64'(wq.size()), 64'd0);
    chk("end_oq_empty", 64'(oq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end
endmodule
